// File: rtl/calendar_counter.sv
// Day/month/year/weekday calendar with Gregorian leap years, deferred day ticks during
// front-panel edits, and a one-cycle clamp of the day field after month/year edits.
module calendar_counter #(
  parameter int YEAR_BITS = 7,
  parameter int YEAR_BASE = 2000,
  parameter int YEAR_MAX  = 99,
  parameter int RST_YEAR  = 21,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1,
  parameter int RST_WDAY  = 5,
  parameter int LEAP_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 day_tick,
  input  logic                 set_en,
  input  logic [1:0]           set_field,
  input  logic                 key_inc,
  input  logic                 key_dec,
  output logic [4:0]           day_o,
  output logic [3:0]           month_o,
  output logic [YEAR_BITS-1:0] year_o,
  output logic [2:0]           wday_o,
  output logic                 leap_o,
  output logic                 year_wrap,
  output logic                 tick_lost
);

  localparam logic [1:0] FIELD_DAY   = 2'd0;
  localparam logic [1:0] FIELD_MONTH = 2'd1;
  localparam logic [1:0] FIELD_YEAR  = 2'd2;
  localparam logic [1:0] FIELD_WDAY  = 2'd3;

  localparam logic [YEAR_BITS-1:0] YEAR_TOP = YEAR_MAX[YEAR_BITS-1:0];
  localparam logic [YEAR_BITS-1:0] YEAR_ONE = {{(YEAR_BITS-1){1'b0}}, 1'b1};
  localparam logic [YEAR_BITS-1:0] YEAR_RST = RST_YEAR[YEAR_BITS-1:0];
  localparam logic [3:0]           MONTH_RST = RST_MONTH[3:0];
  localparam logic [4:0]           DAY_RST   = RST_DAY[4:0];
  localparam logic [2:0]           WDAY_RST  = RST_WDAY[2:0];

  logic [4:0]           day_q, day_d;
  logic [3:0]           month_q, month_d;
  logic [YEAR_BITS-1:0] year_q, year_d;
  logic [2:0]           wday_q, wday_d;
  logic                 pending_q, pending_d;
  logic                 tick_lost_q, tick_lost_d;
  logic                 year_wrap_q, year_wrap_d;

  logic                 leap;
  int                   year_full;
  logic [4:0]           dim;
  logic [4:0]           day_eff;
  logic                 advance;
  logic                 key_act;

  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic lp);
    logic [4:0] r;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
      4'd2:                    r = lp ? 5'd29 : 5'd28;
      default:                 r = 5'd31;
    endcase
    return r;
  endfunction

  always_comb begin
    year_full = YEAR_BASE + int'(year_q);
    leap = (LEAP_EN != 0) && (year_full % 4 == 0) &&
           ((year_full % 100 != 0) || (year_full % 400 == 0));
  end

  // day_eff is the clamped day: an over-range day left by a month/year edit
  // settles to dim on the following cycle, and every update builds on it.
  always_comb begin
    dim     = dim_f(month_q, leap);
    day_eff = (day_q > dim) ? dim : day_q;
  end

  always_comb begin
    day_d       = day_eff;
    month_d     = month_q;
    year_d      = year_q;
    wday_d      = wday_q;
    pending_d   = pending_q;
    tick_lost_d = tick_lost_q;
    year_wrap_d = 1'b0;
    advance     = 1'b0;
    key_act     = set_en && (key_inc ^ key_dec);

    if (set_en) begin
      if (day_tick) begin
        pending_d = 1'b1;
        if (pending_q) tick_lost_d = 1'b1;
      end
      if (key_act) begin
        case (set_field)
          FIELD_DAY: begin
            if (key_inc) day_d = (day_eff == dim)   ? 5'd1 : day_eff + 5'd1;
            else         day_d = (day_eff == 5'd1)  ? dim  : day_eff - 5'd1;
          end
          FIELD_MONTH: begin
            if (key_inc) month_d = (month_q == 4'd12) ? 4'd1  : month_q + 4'd1;
            else         month_d = (month_q == 4'd1)  ? 4'd12 : month_q - 4'd1;
          end
          FIELD_YEAR: begin
            if (key_inc) year_d = (year_q == YEAR_TOP) ? '0       : year_q + YEAR_ONE;
            else         year_d = (year_q == '0)       ? YEAR_TOP : year_q - YEAR_ONE;
          end
          FIELD_WDAY: begin
            if (key_inc) wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            else         wday_d = (wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1;
          end
          default: ;
        endcase
      end
    end else begin
      // A live tick coinciding with the deferred one merges into a single advance.
      advance   = day_tick || pending_q;
      pending_d = 1'b0;
      if (day_tick && pending_q) tick_lost_d = 1'b1;
      if (advance) begin
        wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
        if (day_eff < dim) begin
          day_d = day_eff + 5'd1;
        end else begin
          day_d = 5'd1;
          if (month_q == 4'd12) begin
            month_d = 4'd1;
            if (year_q == YEAR_TOP) begin
              year_d      = '0;
              year_wrap_d = 1'b1;
            end else begin
              year_d = year_q + YEAR_ONE;
            end
          end else begin
            month_d = month_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q       <= DAY_RST;
      month_q     <= MONTH_RST;
      year_q      <= YEAR_RST;
      wday_q      <= WDAY_RST;
      pending_q   <= 1'b0;
      tick_lost_q <= 1'b0;
      year_wrap_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      wday_q      <= wday_d;
      pending_q   <= pending_d;
      tick_lost_q <= tick_lost_d;
      year_wrap_q <= year_wrap_d;
    end
  end

  assign day_o     = day_q;
  assign month_o   = month_q;
  assign year_o    = year_q;
  assign wday_o    = wday_q;
  assign leap_o    = leap;
  assign year_wrap = year_wrap_q;
  assign tick_lost = tick_lost_q;

endmodule
